// File: rtl/ram_burst_master.sv
// Burst controller for one single-port synchronous RAM: accepts write/read burst
// commands and moves words between the RAM and a write stream / back-pressured read stream.
module ram_burst_master #(
  parameter int ADDR_WIDTH   = 4,
  parameter int MEMORY_DEPTH = 8,
  parameter int MEM_WIDTH    = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrite,
  input  logic [ADDR_WIDTH-1:0] CmdAddr,
  input  logic [ADDR_WIDTH:0]   CmdLen,
  input  logic [MEM_WIDTH-1:0]  WrDataIn,
  input  logic                  WrValid,
  output logic                  WrReady,
  output logic [MEM_WIDTH-1:0]  RdDataOut,
  output logic                  RdValid,
  input  logic                  RdReady,
  output logic                  Done,
  output logic                  Err,
  output logic                  MemWrEn,
  output logic                  MemRdEn,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [MEM_WIDTH-1:0]  MemWrData,
  input  logic [MEM_WIDTH-1:0]  MemRdData
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_CAP = 3'd3,
    S_RD_OUT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  err_q, err_d;
  logic [MEM_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  err_out_q, err_out_d;

  // Addresses wrap at the RAM depth, not at the power of two of the address bus.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST_ADDR) begin
      next_addr = '0;
    end else begin
      next_addr = a + ADDR_ONE;
    end
  endfunction

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          addr_d = CmdAddr;
          rem_d  = CmdLen;
          if ({1'b0, CmdAddr} >= DEPTH) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (CmdLen == '0) begin
            state_d = S_DONE;
          end else if (CmdWrite) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (WrValid) begin
          addr_d = next_addr(addr_q);
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rd_data_d = MemRdData;
        addr_d    = next_addr(addr_q);
        rem_d     = rem_q - REM_ONE;
        state_d   = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (RdReady) begin
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_RD_OUT;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered by decoding the state being entered.
    cmd_ready_d = (state_d == S_IDLE);
    wr_ready_d  = (state_d == S_WR);
    mem_rd_en_d = (state_d == S_RD_REQ);
    rd_valid_d  = (state_d == S_RD_OUT);
    done_d      = (state_d == S_DONE);
    err_out_d   = (state_d == S_DONE) & err_d;
  end

  // State and registered-output flops with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      mem_rd_en_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      mem_rd_en_q <= mem_rd_en_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_out_q   <= err_out_d;
    end
  end

  assign CmdReady   = cmd_ready_q;
  assign WrReady    = wr_ready_q;
  assign RdValid    = rd_valid_q;
  assign RdDataOut  = rd_data_q;
  assign Done       = done_q;
  assign Err        = err_out_q;
  assign MemRdEn    = mem_rd_en_q;
  assign MemWrEn    = (state_q == S_WR) & WrValid;
  assign MemAddress = addr_q;
  assign MemWrData  = WrDataIn;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: a RAM model, an event monitor, and a cycle-level burst
// model that predicts every strobe, read-stream word and Done pulse from the command.
module tb_ram_burst_master;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        CmdValid = 1'b0, CmdWrite = 1'b0;
  logic [3:0]  CmdAddr = 4'd0;
  logic [4:0]  CmdLen = 5'd0;
  logic [15:0] WrDataIn = 16'h0;
  logic        WrValid = 1'b0, RdReady = 1'b0;
  logic        CmdReady, WrReady, RdValid, Done, Err, MemWrEn, MemRdEn;
  logic [15:0] RdDataOut, MemWrData, MemRdData;
  logic [3:0]  MemAddress;

  ram_burst_master #(.ADDR_WIDTH(4), .MEMORY_DEPTH(8), .MEM_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
    .CmdAddr(CmdAddr), .CmdLen(CmdLen), .WrDataIn(WrDataIn), .WrValid(WrValid),
    .WrReady(WrReady), .RdDataOut(RdDataOut), .RdValid(RdValid), .RdReady(RdReady),
    .Done(Done), .Err(Err), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemAddress(MemAddress),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 Clk = ~Clk;

  // kind: 1 RAM write, 2 RAM read request, 3 RdValid cycle, 4 Done pulse, 5 both strobes
  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [4:0]  len;
    logic [15:0] d0;
    logic [15:0] step;
    int          exp_off;
    logic        exp_err;
  } vec_t;

  int          cyc = 0;
  int          n_pass = 0, n_total = 0;
  ev_t         log_q[$];
  ev_t         exp_q[$];
  logic [15:0] ram  [0:15];
  logic [15:0] gold [0:7];
  logic [15:0] wdat [0:31];
  bit          pat  [0:511];

  function automatic ev_t mk_ev(input int kind, input int c, input logic [3:0] a, input logic [15:0] d);
    mk_ev = {4'(kind), 16'(c), a, d};
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Single-port RAM with registered read data.
  always @(posedge Clk) begin
    if (MemWrEn) ram[MemAddress] <= MemWrData;
    if (MemRdEn) MemRdData <= ram[MemAddress];
  end

  // Observed-event log, sampled on the falling edge.
  always @(negedge Clk) begin
    if (Rst) begin
      if (MemWrEn) log_q.push_back(mk_ev(1, cyc, MemAddress, MemWrData));
      if (MemRdEn) log_q.push_back(mk_ev(2, cyc, MemAddress, 16'h0));
      if (RdValid) log_q.push_back(mk_ev(3, cyc, 4'd0, RdDataOut));
      if (Done)    log_q.push_back(mk_ev(4, cyc, 4'd0, {15'h0, Err}));
      if (MemWrEn && MemRdEn) log_q.push_back(mk_ev(5, cyc, MemAddress, 16'h0));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill_pat(input int prob);
    for (int i = 0; i < 512; i++) pat[i] = (i >= 400) || ($urandom_range(99) < prob);
  endtask

  task automatic compare_log(input int t0, output int act_off, output logic act_err);
    int m;
    check("event_count", 64'(log_q.size()), 64'(exp_q.size()));
    m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("event%0d", i), 64'(log_q[i]), 64'(exp_q[i]));
    act_off = -1;
    act_err = 1'bx;
    foreach (log_q[i]) begin
      if (log_q[i].kind == 4'd4 && act_off < 0) begin
        act_off = int'(log_q[i].cyc) - t0;
        act_err = log_q[i].data[0];
      end
    end
    log_q.delete();
    exp_q.delete();
  endtask

  // Issue one command; predict its events from the burst rules, drive it, then compare.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [4:0] n,
                         output int act_off, output logic act_err);
    int t0, off, wi, r, c, dn, n_eff;
    logic [3:0] ea;
    logic legal;
    check("cmd_ready_idle", 64'(CmdReady), 64'd1);
    t0 = cyc;
    ea = a;
    legal = (a < 4'd8);
    n_eff = legal ? int'(n) : 0;
    if (n_eff == 0) begin
      dn = 1;
    end else if (wr) begin
      off = 1;
      wi = 0;
      while (wi < n_eff && off < 500) begin
        if (pat[off]) begin
          exp_q.push_back(mk_ev(1, t0 + off, ea, wdat[wi]));
          gold[ea[2:0]] = wdat[wi];
          ea = (ea == 4'd7) ? 4'd0 : ea + 4'd1;
          wi++;
        end
        off++;
      end
      dn = off;
    end else begin
      r = 1;
      for (int i = 0; i < n_eff; i++) begin
        exp_q.push_back(mk_ev(2, t0 + r, ea, 16'h0));
        c = r + 2;
        while (!pat[c] && c < 500) c++;
        for (int x = r + 2; x <= c; x++) exp_q.push_back(mk_ev(3, t0 + x, 4'd0, gold[ea[2:0]]));
        ea = (ea == 4'd7) ? 4'd0 : ea + 4'd1;
        r = c + 1;
      end
      dn = r;
    end
    exp_q.push_back(mk_ev(4, t0 + dn, 4'd0, {15'h0, !legal}));

    CmdValid = 1'b1; CmdWrite = wr; CmdAddr = a; CmdLen = n; WrValid = 1'b0;
    wi = 0;
    for (off = 1; off <= dn; off++) begin
      @(posedge Clk); #1;
      CmdValid = 1'b0;
      WrValid  = wr && (wi < n_eff) && pat[off];
      WrDataIn = WrValid ? wdat[wi] : 16'($urandom);
      if (WrValid) wi++;
      RdReady  = pat[off];
    end
    @(posedge Clk); #1;
    WrValid = 1'b0;
    RdReady = 1'b0;
    compare_log(t0, act_off, act_err);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_CmdReady"}, 64'(CmdReady), 64'd1);
    check({tag, "_WrReady"}, 64'(WrReady), 64'd0);
    check({tag, "_RdValid"}, 64'(RdValid), 64'd0);
    check({tag, "_Done"}, 64'(Done), 64'd0);
    check({tag, "_Err"}, 64'(Err), 64'd0);
    check({tag, "_MemWrEn"}, 64'(MemWrEn), 64'd0);
    check({tag, "_MemRdEn"}, 64'(MemRdEn), 64'd0);
    check({tag, "_RdDataOut"}, 64'(RdDataOut), 64'd0);
    check({tag, "_MemAddress"}, 64'(MemAddress), 64'd0);
  endtask

  initial begin
    vec_t tbl [11];
    int   ao, t0;
    logic ae;
    logic wr;
    logic [3:0] a;
    logic [4:0] n;

    tbl[0]  = '{1'b1, 4'd0, 5'd8,  16'h0100, 16'h0101, 9,  1'b0};
    tbl[1]  = '{1'b1, 4'd2, 5'd3,  16'h1111, 16'h1111, 4,  1'b0};
    tbl[2]  = '{1'b0, 4'd2, 5'd3,  16'h0000, 16'h0000, 10, 1'b0};
    tbl[3]  = '{1'b1, 4'd6, 5'd4,  16'h00A0, 16'h0001, 5,  1'b0};
    tbl[4]  = '{1'b0, 4'd6, 5'd4,  16'h0000, 16'h0000, 13, 1'b0};
    tbl[5]  = '{1'b1, 4'd5, 5'd0,  16'h0000, 16'h0000, 1,  1'b0};
    tbl[6]  = '{1'b0, 4'd9, 5'd3,  16'h0000, 16'h0000, 1,  1'b1};
    tbl[7]  = '{1'b1, 4'd9, 5'd2,  16'h0000, 16'h0000, 1,  1'b1};
    tbl[8]  = '{1'b1, 4'd0, 5'd10, 16'hC000, 16'h0003, 11, 1'b0};
    tbl[9]  = '{1'b0, 4'd1, 5'd9,  16'h0000, 16'h0000, 28, 1'b0};
    tbl[10] = '{1'b0, 4'd7, 5'd1,  16'h0000, 16'h0000, 4,  1'b0};

    repeat (3) @(posedge Clk);
    #1;
    reset_checks("por");
    Rst = 1'b1;
    @(posedge Clk); #1;

    foreach (tbl[k]) begin
      for (int i = 0; i < 32; i++) wdat[i] = tbl[k].d0 + 16'(i) * tbl[k].step;
      fill_pat(100);
      run_cmd(tbl[k].wr, tbl[k].addr, tbl[k].len, ao, ae);
      check($sformatf("tbl%0d_done_off", k), 64'(ao), 64'(tbl[k].exp_off));
      check($sformatf("tbl%0d_err", k), 64'(ae), 64'(tbl[k].exp_err));
    end

    // Read with the consumer stalling 5 cycles on the first word.
    fill_pat(100);
    for (int i = 3; i <= 7; i++) pat[i] = 1'b0;
    run_cmd(1'b0, 4'd2, 5'd2, ao, ae);
    check("bp_read_done_off", 64'(ao), 64'd12);

    // Reset during the 2nd write of a 5-word burst.
    t0 = cyc;
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddr = 4'd3; CmdLen = 5'd5;
    @(posedge Clk); #1;
    CmdValid = 1'b0; WrValid = 1'b1; WrDataIn = 16'h5A5A;
    @(posedge Clk); #1;
    WrDataIn = 16'h6B6B;
    Rst = 1'b0;
    #1;
    reset_checks("mid_rst");
    @(posedge Clk); #1;
    WrValid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    gold[3] = 16'h5A5A;
    exp_q.push_back(mk_ev(1, t0 + 1, 4'd3, 16'h5A5A));
    compare_log(t0, ao, ae);
    check("rst_no_done", 64'(ao), 64'hFFFF_FFFF_FFFF_FFFF);
    wdat[0] = 16'hBEEF;
    fill_pat(100);
    run_cmd(1'b1, 4'd0, 5'd1, ao, ae);
    check("post_rst_wr_done_off", 64'(ao), 64'd2);
    run_cmd(1'b0, 4'd0, 5'd4, ao, ae);

    // Write stalled for 3 cycles after its first word.
    for (int i = 0; i < 32; i++) wdat[i] = 16'h7700 + 16'(i);
    fill_pat(100);
    pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b0;
    run_cmd(1'b1, 4'd4, 5'd3, ao, ae);
    check("wr_stall_done_off", 64'(ao), 64'd7);

    // Randomized commands and stream handshakes.
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom_range(1));
      a  = ($urandom_range(9) == 0) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(7));
      n  = 5'($urandom_range(12));
      for (int i = 0; i < 32; i++) wdat[i] = 16'($urandom);
      fill_pat(40 + $urandom_range(60));
      run_cmd(wr, a, n, ao, ae);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
